// File: rtl/arp_frame_tx.sv
// ARP frame transmitter, GMII side.
// On a start pulse in idle, streams one complete Ethernet II ARP frame (request or reply)
// byte-per-clock: preamble/SFD, Ethernet header, 28-byte ARP body, zero pad, CRC-32 FCS.
// It then holds the line idle for the inter-frame gap before accepting a new start.
// Ports:
//   clk          GMII transmit clock, all logic on the rising edge
//   rst          synchronous reset, active-high
//   arp_tx_en    start pulse, honoured only while idle
//   arp_tx_type  0: request, 1: reply (latched with arp_tx_en)
//   des_mac      peer MAC, latched with arp_tx_en (zero selects DES_MAC)
//   des_ip       peer IP, latched with arp_tx_en (zero selects DES_IP)
//   gmii_tx_en   GMII transmit enable (registered)
//   gmii_txd     GMII transmit data (registered, 0 when gmii_tx_en is low)
//   tx_busy      high while a frame or its gap is in progress
//   tx_done      one-cycle pulse in the first gap cycle
module arp_frame_tx #(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = 32'hC0_A8_01_0A,
  parameter logic [47:0] DES_MAC   = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [31:0] DES_IP    = 32'hC0_A8_01_66
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arp_tx_en,
  input  logic        arp_tx_type,
  input  logic [47:0] des_mac,
  input  logic [31:0] des_ip,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd,
  output logic        tx_busy,
  output logic        tx_done
);

  typedef enum logic [2:0] {
    StIdle, StPreamble, StEthHdr, StArpBody, StPad, StFcs, StIfg
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        type_q, type_d;
  logic [47:0] tmac_q, tmac_d;
  logic [31:0] tip_q, tip_d;
  logic [31:0] crc_q, crc_d;
  logic        tx_en_q, tx_en_d;
  logic [7:0]  txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [111:0] hdr_vec;
  logic [223:0] body_vec;
  logic [31:0]  fcs;
  logic [6:0]   hdr_idx;
  logic [7:0]   body_idx;
  logic [4:0]   fcs_idx;

  // Reflected CRC-32, one byte processed LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  // Whole header and body as MSB-first vectors; the byte counter picks a slice.
  assign hdr_vec  = {(type_q ? tmac_q : 48'hFFFF_FFFF_FFFF), BOARD_MAC, 16'h0806};
  assign body_vec = {16'h0001, 16'h0800, 8'h06, 8'h04,
                     (type_q ? 16'h0002 : 16'h0001),
                     BOARD_MAC, BOARD_IP,
                     (type_q ? tmac_q : 48'h0), tip_q};
  assign fcs      = ~crc_q;
  assign hdr_idx  = 7'd104 - {cnt_q[3:0], 3'b000};
  assign body_idx = 8'd216 - {cnt_q, 3'b000};
  assign fcs_idx  = {cnt_q[1:0], 3'b000};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 5'd1;
    type_d  = type_q;
    tmac_d  = tmac_q;
    tip_d   = tip_q;
    crc_d   = crc_q;
    tx_en_d = 1'b0;
    txd_d   = 8'h00;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (arp_tx_en) begin
          state_d = StPreamble;
          type_d  = arp_tx_type;
          tmac_d  = (des_mac == 48'h0) ? DES_MAC : des_mac;
          tip_d   = (des_ip == 32'h0) ? DES_IP : des_ip;
        end
      end
      StPreamble: begin
        tx_en_d = 1'b1;
        txd_d   = (cnt_q == 5'd7) ? 8'hD5 : 8'h55;
        crc_d   = 32'hFFFF_FFFF;
        if (cnt_q == 5'd7) begin
          state_d = StEthHdr;
          cnt_d   = '0;
        end
      end
      StEthHdr: begin
        tx_en_d = 1'b1;
        txd_d   = hdr_vec[hdr_idx +: 8];
        crc_d   = crc_byte(crc_q, txd_d);
        if (cnt_q == 5'd13) begin
          state_d = StArpBody;
          cnt_d   = '0;
        end
      end
      StArpBody: begin
        tx_en_d = 1'b1;
        txd_d   = body_vec[body_idx +: 8];
        crc_d   = crc_byte(crc_q, txd_d);
        if (cnt_q == 5'd27) begin
          state_d = StPad;
          cnt_d   = '0;
        end
      end
      StPad: begin
        tx_en_d = 1'b1;
        crc_d   = crc_byte(crc_q, 8'h00);
        if (cnt_q == 5'd17) begin
          state_d = StFcs;
          cnt_d   = '0;
        end
      end
      StFcs: begin
        // CRC holds here; the complemented value goes out low byte first.
        tx_en_d = 1'b1;
        txd_d   = fcs[fcs_idx +: 8];
        if (cnt_q == 5'd3) begin
          state_d = StIfg;
          cnt_d   = '0;
        end
      end
      StIfg: begin
        done_d = (cnt_q == 5'd0);
        if (cnt_q == 5'd11) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      type_q  <= 1'b0;
      tmac_q  <= '0;
      tip_q   <= '0;
      crc_q   <= 32'hFFFF_FFFF;
      tx_en_q <= 1'b0;
      txd_q   <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      tmac_q  <= tmac_d;
      tip_q   <= tip_d;
      crc_q   <= crc_d;
      tx_en_q <= tx_en_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign gmii_tx_en = tx_en_q;
  assign gmii_txd   = txd_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;

endmodule
